// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the unified-memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned MAX_LAT = 4;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_ILL} size_e;
    typedef enum logic {IDLE, BUSY} state_e;
    typedef enum logic {OWN_I, OWN_D} owner_e;

    // One latency-pipe slot; store marks a D write whose ack carries zero data.
    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   store;
    } lat_ent_t;

    function automatic logic misaligned(input logic [1:0] addr_lo, input size_e size);
        case (size)
            SZ_B:    misaligned = 1'b0;
            SZ_H:    misaligned = addr_lo[0];
            SZ_W:    misaligned = (addr_lo != 2'b00);
            default: misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_arb_lat_pipe.sv
// MEM_LAT-deep shift register tracking which requester owns each in-flight access.
module mem_arb_lat_pipe
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic     clock,
    input  logic     reset_n,
    input  lat_ent_t i_ent,
    output lat_ent_t o_ent
);

    lat_ent_t r_stage [MEM_LAT];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < MEM_LAT; k++) begin
                r_stage[k] <= '0;
            end
        end else begin
            r_stage[0] <= i_ent;
            for (int unsigned k = 1; k < MEM_LAT; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    assign o_ent = r_stage[MEM_LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for a single-port unified memory with starvation guard and misalignment trap.
// Optional MEM_ARB_PERF_EN adds grant/conflict performance counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              i_req_valid,
    output logic              i_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_rsp_valid,
    output logic [XLEN-1:0]   i_rsp_data,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic              d_req_we,
    input  logic [1:0]        d_req_size,
    input  logic [XLEN-1:0]   d_req_wdata,
    output logic              d_rsp_valid,
    output logic [XLEN-1:0]   d_rsp_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_size,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
`ifdef MEM_ARB_PERF_EN
    output logic [XLEN-1:0]   perf_i_grants,
    output logic [XLEN-1:0]   perf_d_grants,
    output logic [XLEN-1:0]   perf_conflicts,
`endif
    output logic              fault
);

    localparam int unsigned LAT_W = $clog2(MAX_LAT + 1);
    localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [STV_W-1:0] STV_TOP = STV_W'(STARVE_MAX);

    state_e           r_state;
    logic [LAT_W-1:0] r_lat_cnt;
    logic [STV_W-1:0] r_starve;
    logic             r_fault;
    logic             r_mis_rsp;

    logic     w_can_grant, w_i_grant, w_d_grant, w_d_mis, w_mem_go, w_d_mem_rsp;
    lat_ent_t w_pipe_in, w_pipe_out;

    always_comb begin
        w_can_grant = reset_n && (r_state == IDLE);
        w_i_grant   = w_can_grant && i_req_valid && (!d_req_valid || (r_starve == STV_TOP));
        w_d_grant   = w_can_grant && d_req_valid && !w_i_grant;
        w_d_mis     = w_d_grant && misaligned(d_req_addr[1:0], size_e'(d_req_size));
        w_mem_go    = w_i_grant || (w_d_grant && !w_d_mis);
    end

    assign i_req_ready = w_i_grant;
    assign d_req_ready = w_d_grant;

    always_comb begin
        mem_en    = w_mem_go;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_size  = '0;
        mem_wdata = '0;
        if (w_i_grant) begin
            mem_addr = i_req_addr;
            mem_size = SZ_W;
        end else if (w_d_grant && !w_d_mis) begin
            mem_we    = d_req_we;
            mem_addr  = d_req_addr;
            mem_size  = d_req_size;
            mem_wdata = d_req_we ? d_req_wdata : '0;
        end
    end

    // BUSY returns to IDLE on the edge into the response cycle, so that cycle may grant again.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_lat_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_mem_go && (MEM_LAT > 1)) begin
                        r_state   <= BUSY;
                        r_lat_cnt <= LAT_W'(MEM_LAT - 1);
                    end
                end
                BUSY: begin
                    if (r_lat_cnt <= LAT_W'(1)) begin
                        r_state   <= IDLE;
                        r_lat_cnt <= '0;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - LAT_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_starve  <= '0;
            r_fault   <= 1'b0;
            r_mis_rsp <= 1'b0;
        end else begin
            r_mis_rsp <= w_d_mis;
            if (w_d_mis) begin
                r_fault <= 1'b1;
            end
            if (!i_req_valid || w_i_grant) begin
                r_starve <= '0;
            end else if (r_starve != STV_TOP) begin
                r_starve <= r_starve + STV_W'(1);
            end
        end
    end

    always_comb begin
        w_pipe_in.valid = w_mem_go;
        w_pipe_in.owner = w_i_grant ? OWN_I : OWN_D;
        w_pipe_in.store = w_mem_go && w_d_grant && d_req_we;
    end

    mem_arb_lat_pipe #(.MEM_LAT(MEM_LAT)) u_lat_pipe (
        .clock   (clock),
        .reset_n (reset_n),
        .i_ent   (w_pipe_in),
        .o_ent   (w_pipe_out)
    );

    // Responses are masked while reset is held so that in-flight data never escapes.
    assign w_d_mem_rsp = reset_n && w_pipe_out.valid && (w_pipe_out.owner == OWN_D);
    assign i_rsp_valid = reset_n && w_pipe_out.valid && (w_pipe_out.owner == OWN_I);
    assign i_rsp_data  = i_rsp_valid ? mem_rdata : '0;
    assign d_rsp_valid = w_d_mem_rsp || (reset_n && r_mis_rsp);
    assign d_rsp_data  = (w_d_mem_rsp && !w_pipe_out.store) ? mem_rdata : '0;
    assign fault       = r_fault;

`ifdef MEM_ARB_PERF_EN
    logic [XLEN-1:0] r_perf_i, r_perf_d, r_perf_c;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_perf_i <= '0;
            r_perf_d <= '0;
            r_perf_c <= '0;
        end else begin
            if (w_i_grant) r_perf_i <= r_perf_i + XLEN'(1);
            if (w_d_grant) r_perf_d <= r_perf_d + XLEN'(1);
            if (i_req_valid && d_req_valid) r_perf_c <= r_perf_c + XLEN'(1);
        end
    end

    assign perf_i_grants  = r_perf_i;
    assign perf_d_grants  = r_perf_d;
    assign perf_conflicts = r_perf_c;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (MEM_LAT 1,2,3) fed identical request streams.
module tb_mem_port_arbiter;

    localparam int NDUT = 3;
    localparam int SMAX = 4;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    logic        ivld [NDUT], irdy [NDUT], irv [NDUT];
    logic [31:0] iaddr [NDUT], ird [NDUT];
    logic        dvld [NDUT], drdy [NDUT], dwe [NDUT], drv [NDUT];
    logic [31:0] daddr [NDUT], dwd [NDUT], drd [NDUT];
    logic [1:0]  dsize [NDUT], msize [NDUT];
    logic        men [NDUT], mwe [NDUT], flt [NDUT];
    logic [31:0] maddr [NDUT], mwd [NDUT], mrd [NDUT];
`ifdef MEM_ARB_PERF_EN
    logic [31:0] pig [NDUT], pdg [NDUT], pcf [NDUT];
`endif

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        mem_port_arbiter #(.XLEN(32), .ADDR_W(32), .MEM_LAT(g + 1), .STARVE_MAX(SMAX)) u_dut (
            .clock       (clock),
            .reset_n     (reset_n),
            .i_req_valid (ivld[g]),
            .i_req_ready (irdy[g]),
            .i_req_addr  (iaddr[g]),
            .i_rsp_valid (irv[g]),
            .i_rsp_data  (ird[g]),
            .d_req_valid (dvld[g]),
            .d_req_ready (drdy[g]),
            .d_req_addr  (daddr[g]),
            .d_req_we    (dwe[g]),
            .d_req_size  (dsize[g]),
            .d_req_wdata (dwd[g]),
            .d_rsp_valid (drv[g]),
            .d_rsp_data  (drd[g]),
            .mem_en      (men[g]),
            .mem_we      (mwe[g]),
            .mem_addr    (maddr[g]),
            .mem_size    (msize[g]),
            .mem_wdata   (mwd[g]),
            .mem_rdata   (mrd[g]),
`ifdef MEM_ARB_PERF_EN
            .perf_i_grants  (pig[g]),
            .perf_d_grants  (pdg[g]),
            .perf_conflicts (pcf[g]),
`endif
            .fault       (flt[g])
        );
    end

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [1:0]  size;
        logic [31:0] wd;
    } dreq_t;

    logic [31:0] ilist [$];
    dreq_t       dlist [$];
    int          ipos [NDUT], dpos [NDUT];
    bit          itook [NDUT], dtook [NDUT];

    // Reference model: time-based view (next free cycle, response calendar).
    int          cyc;
    int          busy_until [NDUT];
    int          starve [NDUT];
    bit          fault_m [NDUT];
    bit          s_iv [NDUT][8], s_dv [NDUT][8];
    logic [31:0] s_id [NDUT][8], s_dd [NDUT][8];
    // Memory environment calendar.
    bit          e_v [NDUT][8];
    logic [31:0] e_d [NDUT][8];

    int n_vec, n_err;

    int          ig_n [NDUT], ig_first [NDUT], ig_last [NDUT];
    int          ir_n [NDUT], ir_first [NDUT], ir_last [NDUT];
    int          dg_first [NDUT], dr_n [NDUT], dr_first [NDUT];
    logic [31:0] d_first_data [NDUT];
    logic [9:0]  hist0;
    int          win_n0;
    bit          snap;
    logic [31:0] sp_i, sp_d, sp_c;

    function automatic logic [31:0] pat(logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic bit mis_m(logic [31:0] a, logic [1:0] sz);
        return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
    endfunction

    task automatic check(string name, int k, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d cyc %0d: got %h want %h", name, k, cyc, act, exp);
        end
    endtask

    task automatic check_cycle();
        for (int k = 0; k < NDUT; k++) begin
            int lat, sl;
            bit rst, ok, ei, ed, mis, go, ewe, eiv, edv;
            lat = k + 1;
            sl  = cyc % 8;
            rst = !reset_n;
            ok  = !rst && (cyc >= busy_until[k]);
            ei  = ok && ivld[k] && (!dvld[k] || starve[k] == SMAX);
            ed  = ok && dvld[k] && !ei;
            mis = ed && mis_m(daddr[k], dsize[k]);
            go  = ei || (ed && !mis);
            ewe = ed && !mis && dwe[k];
            eiv = !rst && s_iv[k][sl];
            edv = !rst && s_dv[k][sl];

            check("i_req_ready", k, 32'(irdy[k]), 32'(ei));
            check("d_req_ready", k, 32'(drdy[k]), 32'(ed));
            check("mem_en", k, 32'(men[k]), 32'(go));
            check("mem_we", k, 32'(mwe[k]), 32'(ewe));
            if (go) begin
                check("mem_addr", k, maddr[k], ei ? iaddr[k] : daddr[k]);
                check("mem_size", k, 32'(msize[k]), ei ? 32'd2 : 32'(dsize[k]));
            end
            if (ewe) check("mem_wdata", k, mwd[k], dwd[k]);
            check("i_rsp_valid", k, 32'(irv[k]), 32'(eiv));
            if (eiv) check("i_rsp_data", k, ird[k], s_id[k][sl]);
            check("d_rsp_valid", k, 32'(drv[k]), 32'(edv));
            if (edv) check("d_rsp_data", k, drd[k], s_dd[k][sl]);
            check("fault", k, 32'(flt[k]), 32'(fault_m[k]));

            s_iv[k][sl] = 0;
            s_dv[k][sl] = 0;
            if (rst) begin
                for (int j = 0; j < 8; j++) begin
                    s_iv[k][j] = 0;
                    s_dv[k][j] = 0;
                end
                starve[k]     = 0;
                busy_until[k] = 0;
                fault_m[k]    = 0;
            end else begin
                if (ei) begin
                    s_iv[k][(cyc + lat) % 8] = 1;
                    s_id[k][(cyc + lat) % 8] = pat(iaddr[k]);
                    busy_until[k] = cyc + lat;
                end
                if (ed && mis) begin
                    s_dv[k][(cyc + 1) % 8] = 1;
                    s_dd[k][(cyc + 1) % 8] = '0;
                    fault_m[k] = 1;
                end else if (ed) begin
                    s_dv[k][(cyc + lat) % 8] = 1;
                    s_dd[k][(cyc + lat) % 8] = dwe[k] ? 32'h0 : pat(daddr[k]);
                    busy_until[k] = cyc + lat;
                end
                if (!ivld[k] || ei) starve[k] = 0;
                else if (starve[k] < SMAX) starve[k] = starve[k] + 1;
            end

            if (men[k] && !mwe[k]) begin
                e_v[k][(cyc + lat) % 8] = 1;
                e_d[k][(cyc + lat) % 8] = pat(maddr[k]);
            end
            itook[k] = ivld[k] && irdy[k];
            dtook[k] = dvld[k] && drdy[k];

            if (irdy[k]) begin
                if (ig_n[k] == 0) ig_first[k] = cyc;
                ig_last[k] = cyc;
                ig_n[k]++;
            end
            if (irv[k]) begin
                if (ir_n[k] == 0) ir_first[k] = cyc;
                ir_last[k] = cyc;
                ir_n[k]++;
            end
            if (drdy[k] && dg_first[k] < 0) dg_first[k] = cyc;
            if (drv[k]) begin
                if (dr_n[k] == 0) begin
                    dr_first[k]     = cyc;
                    d_first_data[k] = drd[k];
                end
                dr_n[k]++;
            end
        end
`ifdef MEM_ARB_PERF_EN
        if (win_n0 == 10 && !snap) begin
            snap = 1;
            sp_i = pig[0];
            sp_d = pdg[0];
            sp_c = pcf[0];
        end
`endif
        if ((irdy[0] || drdy[0]) && win_n0 < 10) begin
            hist0 = {hist0[8:0], irdy[0]};
            win_n0++;
        end
        cyc++;
    endtask

    task automatic drive();
        for (int k = 0; k < NDUT; k++) begin
            int sl;
            sl = cyc % 8;
            ivld[k]  = ipos[k] < ilist.size();
            iaddr[k] = ivld[k] ? ilist[ipos[k]] : 32'h0;
            dvld[k]  = dpos[k] < dlist.size();
            daddr[k] = dvld[k] ? dlist[dpos[k]].addr : 32'h0;
            dwe[k]   = dvld[k] ? dlist[dpos[k]].we : 1'b0;
            dsize[k] = dvld[k] ? dlist[dpos[k]].size : 2'd0;
            dwd[k]   = dvld[k] ? dlist[dpos[k]].wd : 32'h0;
            mrd[k]   = e_v[k][sl] ? e_d[k][sl] : 32'hDEAD_BEEF;
            e_v[k][sl] = 0;
        end
    endtask

    task automatic step();
        @(negedge clock);
        check_cycle();
        @(posedge clock);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            if (itook[k]) ipos[k]++;
            if (dtook[k]) dpos[k]++;
            itook[k] = 0;
            dtook[k] = 0;
        end
        drive();
    endtask

    task automatic clear_logs();
        for (int k = 0; k < NDUT; k++) begin
            ig_n[k] = 0; ig_first[k] = -1; ig_last[k] = -1;
            ir_n[k] = 0; ir_first[k] = -1; ir_last[k] = -1;
            dg_first[k] = -1; dr_n[k] = 0; dr_first[k] = -1;
            d_first_data[k] = 32'hFFFF_FFFF;
        end
        hist0  = '0;
        win_n0 = 0;
        snap   = 0;
    endtask

    task automatic start();
        for (int k = 0; k < NDUT; k++) begin
            ipos[k] = 0;
            dpos[k] = 0;
        end
        clear_logs();
        drive();
    endtask

    task automatic add_d(logic [31:0] a, logic we, logic [1:0] sz, logic [31:0] wd);
        dreq_t r;
        r.addr = a; r.we = we; r.size = sz; r.wd = wd;
        dlist.push_back(r);
    endtask

    function automatic bit all_done();
        for (int k = 0; k < NDUT; k++) begin
            if (ipos[k] < ilist.size() || dpos[k] < dlist.size()) return 0;
        end
        return 1;
    endfunction

    task automatic run(string name, int budget);
        for (int c = 0; c < budget && !all_done(); c++) step();
        n_vec++;
        if (!all_done()) begin
            n_err++;
            $display("FAIL %s_timeout: requests still pending after %0d cycles", name, budget);
        end
        repeat (6) step();
    endtask

    task automatic lit(string name, logic [31:0] act, logic [31:0] exp);
        check(name, -1, act, exp);
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0;
        for (int k = 0; k < NDUT; k++) begin
            busy_until[k] = 0; starve[k] = 0; fault_m[k] = 0;
            itook[k] = 0; dtook[k] = 0;
            for (int j = 0; j < 8; j++) begin
                s_iv[k][j] = 0; s_dv[k][j] = 0; e_v[k][j] = 0;
                s_id[k][j] = '0; s_dd[k][j] = '0; e_d[k][j] = '0;
            end
        end
        reset_n = 1'b0;
        ilist.delete();
        dlist.delete();
        start();
        repeat (3) step();
        for (int k = 0; k < NDUT; k++) begin
            lit("reset_fault", 32'(flt[k]), 32'd0);
            lit("reset_ready", 32'(irdy[k] | drdy[k] | men[k]), 32'd0);
            lit("reset_rsp", 32'(irv[k] | drv[k]), 32'd0);
        end
        reset_n = 1'b1;

        // Fetch-only stream, back-to-back.
        ilist = '{32'h0, 32'h4, 32'h8};
        start();
        run("ionly", 40);
        lit("ionly_l1_grants", 32'(ig_n[0]), 32'd3);
        lit("ionly_l1_backtoback", 32'(ig_last[0] - ig_first[0]), 32'd2);
        lit("ionly_l1_rsp_lat", 32'(ir_first[0] - ig_first[0]), 32'd1);
        lit("ionly_l1_rsp_span", 32'(ir_last[0] - ir_first[0]), 32'd2);
        lit("ionly_l3_rsp_lat", 32'(ir_first[2] - ig_first[2]), 32'd3);

        // Sustained contention after a fresh reset.
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        ilist = '{32'h10, 32'h14};
        for (int j = 0; j < 9; j++) add_d(32'h200 + 32'(4 * j), 1'b0, 2'd2, 32'h0);
        start();
        run("contend", 80);
        lit("contend_l1_pattern", 32'(hist0), 32'h021);
`ifdef MEM_ARB_PERF_EN
        lit("perf_conflicts", sp_c, 32'd10);
        lit("perf_d_grants", sp_d, 32'd8);
        lit("perf_i_grants", sp_i, 32'd2);
`endif

        // Load followed by a queued fetch.
        ilist = '{32'h300};
        dlist.delete();
        add_d(32'h100, 1'b0, 2'd2, 32'h0);
        start();
        run("load_fetch", 40);
        lit("l3_fetch_wait", 32'(ig_first[2] - dg_first[2]), 32'd3);
        lit("l3_load_lat", 32'(dr_first[2] - dg_first[2]), 32'd3);
        lit("l3_load_data", d_first_data[2], 32'hC0DE_0100);

        // Misaligned and illegal data accesses mixed with legal ones.
        ilist = '{32'h500};
        dlist.delete();
        add_d(32'h102, 1'b1, 2'd2, 32'h1111_2222);
        add_d(32'h001, 1'b0, 2'd1, 32'h0);
        add_d(32'h008, 1'b0, 2'd3, 32'h0);
        add_d(32'h003, 1'b0, 2'd0, 32'h0);
        add_d(32'h040, 1'b1, 2'd2, 32'hA5A5_5A5A);
        add_d(32'h006, 1'b0, 2'd1, 32'h0);
        start();
        run("misalign", 60);
        for (int k = 0; k < NDUT; k++) begin
            lit("mis_rsp_lat", 32'(dr_first[k] - dg_first[k]), 32'd1);
            lit("mis_rsp_data", d_first_data[k], 32'd0);
            lit("mis_fault_sticky", 32'(flt[k]), 32'd1);
        end

        // Reset while a load is in flight.
        ilist.delete();
        dlist.delete();
        add_d(32'h600, 1'b0, 2'd2, 32'h0);
        start();
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        clear_logs();
        repeat (6) step();
        lit("rst_l2_dropped", 32'(dr_n[1]), 32'd0);
        for (int k = 0; k < NDUT; k++) begin
            lit("rst_fault_clear", 32'(flt[k]), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
